// File: rtl/wb_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_responder_pkg
// Description : Shared types, bus constants and address helpers for the
//               Wishbone memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_responder_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // Byte address to 32-bit word index.
    function automatic logic [31:0] word_index(input logic [31:0] byte_adr);
        return byte_adr >> 2;
    endfunction

    function automatic logic index_in_range(input logic [31:0] idx,
                                            input int unsigned depth);
        return (idx < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : wb_responder_mem
// Description : DEPTH x 32 register array with per-byte write enables,
//               asynchronous read and synchronous clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_responder_mem
    import wb_responder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [WB_SEL_WIDTH-1:0]  i_wr_sel,
    input  logic [WB_DATA_WIDTH-1:0] i_wr_data,
    output logic [WB_DATA_WIDTH-1:0] o_rd_data
);

    logic [WB_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [WB_DATA_WIDTH-1:0] w_mask;

    generate
        for (genvar g = 0; g < WB_SEL_WIDTH; g++) begin : g_lane_mask
            assign w_mask[8*g +: 8] = {8{i_wr_sel[g]}};
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_idx] <= (r_mem[i_idx] & ~w_mask) | (i_wr_data & w_mask);
        end
    end

    assign o_rd_data = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/wishbone_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_mem_responder
// Description : Wishbone classic single-transfer slave backed by a byte-laned
//               register memory with programmable wait states.
//               Define WB_RESPONDER_ERR_EN to terminate out-of-range accesses
//               with wb_err_o instead of wb_ack_o.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_mem_responder
    import wb_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [ADDR_WIDTH-1:0]    wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic [15:0]              access_count_o
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_state_e                r_state;
    wb_state_e                w_state_nxt;
    logic [3:0]               r_wait_cnt;
    logic [3:0]               w_wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0]    r_adr;
    logic                     r_we;
    logic [WB_SEL_WIDTH-1:0]  r_sel;
    logic [WB_DATA_WIDTH-1:0] r_dat;
    logic                     r_ack;
    logic [WB_DATA_WIDTH-1:0] r_dat_o;
    logic [15:0]              r_access_count;

    logic                     w_capture;
    logic                     w_ack_nxt;
    logic [WB_DATA_WIDTH-1:0] w_dat_nxt;
    logic                     w_wr_en;
    logic                     w_term;
    logic [31:0]              w_index;
    logic                     w_in_range;
    logic [WB_DATA_WIDTH-1:0] w_rd_data;

`ifdef WB_RESPONDER_ERR_EN
    logic                     r_err;
    logic                     w_err_nxt;
`endif

    // Decode always works on the latched address, never the live bus.
    assign w_index    = word_index(32'(r_adr));
    assign w_in_range = index_in_range(w_index, DEPTH);

    wb_responder_mem #(
        .DEPTH (DEPTH),
        .IDX_W (c_IDX_W)
    ) u_mem (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .i_wr_en   (w_wr_en),
        .i_idx     (w_index[c_IDX_W-1:0]),
        .i_wr_sel  (r_sel),
        .i_wr_data (r_dat),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_capture      = 1'b0;
        w_ack_nxt      = 1'b0;
        w_dat_nxt      = '0;
        w_wr_en        = 1'b0;
`ifdef WB_RESPONDER_ERR_EN
        w_err_nxt      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_wait_cnt_nxt = 4'(WAIT_STATES - 1);
                        w_state_nxt    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!(wb_cyc_i && wb_stb_i)) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (w_in_range) begin
                    w_ack_nxt = 1'b1;
                    w_wr_en   = r_we;
                    if (!r_we) begin
                        w_dat_nxt = w_rd_data;
                    end
                end else begin
`ifdef WB_RESPONDER_ERR_EN
                    w_err_nxt = 1'b1;
`else
                    w_ack_nxt = 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef WB_RESPONDER_ERR_EN
    assign w_term = w_ack_nxt | w_err_nxt;
`else
    assign w_term = w_ack_nxt;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= 4'd0;
            r_adr          <= '0;
            r_we           <= 1'b0;
            r_sel          <= '0;
            r_dat          <= '0;
            r_ack          <= 1'b0;
            r_dat_o        <= '0;
            r_access_count <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_capture) begin
                r_adr <= wb_adr_i;
                r_we  <= wb_we_i;
                r_sel <= wb_sel_i;
                r_dat <= wb_dat_i;
            end
            r_ack   <= w_ack_nxt;
            r_dat_o <= w_dat_nxt;
            if (w_term && (r_access_count != 16'hFFFF)) begin
                r_access_count <= r_access_count + 16'd1;
            end
        end
    end

`ifdef WB_RESPONDER_ERR_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end
    assign wb_err_o = r_err;
`else
    assign wb_err_o = 1'b0;
`endif

    assign wb_ack_o       = r_ack;
    assign wb_dat_o       = r_dat_o;
    assign access_count_o = r_access_count;

endmodule
`default_nettype wire

// File: doc/wishbone_mem_responder.md
# wishbone_mem_responder

Wishbone classic-cycle slave: answers the single-transfer reads and writes issued by the testbench wishbone driver with a small byte-laned register memory. It has a programmable wait-state count and flags out-of-range addresses. It sits on the testbench wishbone bus in place of, or alongside, the quad UART, so driver timing and byte-select handling can be checked against a known responder.

## Interface
Parameters:
- ADDR_WIDTH, 8, byte-address width of wb_adr_i.
- DEPTH, 16, number of 32-bit words; must be a power of two and ≤ 2^(ADDR_WIDTH-2).
- WAIT_STATES, 2, idle cycles inserted before ack; range 0..15.

Ports:
- wb_clk_i  in  1  single clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_adr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte lane enables; bit n selects bits [8n+7:8n].
- wb_we_i  in  1  1 = write, 0 = read.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  bus cycle valid.
- wb_ack_o  out  1  normal termination, one-cycle pulse.
- wb_err_o  out  1  error termination, one-cycle pulse (only with WB_RESPONDER_ERR_EN).
- access_count_o  out  16  count of terminated transfers (ack or err).

## Operation
- State machine: IDLE, WAIT, RESP.
- IDLE: on wb_cyc_i & wb_stb_i, latch adr, we, sel and dat_i.
  - If WAIT_STATES = 0, go to RESP.
  - Otherwise load wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter; at 0 go to RESP.
  - If wb_cyc_i or wb_stb_i is low in WAIT (abort): go to IDLE, no write, no ack, no count.
- RESP: drive wb_ack_o or wb_err_o high for exactly one cycle, then go to IDLE.
- Word index = latched adr[ADDR_WIDTH-1:2]. In range when index < DEPTH.
- In-range write: update only the bytes enabled by the latched sel, on the edge that raises ack.
- In-range read: wb_dat_o = mem[index] while ack is high; sel is ignored on reads. wb_dat_o = 0 at all other times.
- sel = 0 write: acked, memory unchanged.
- access_count_o increments on each ack or err pulse and saturates at 16'hFFFF.
- Reset: state IDLE, all memory words 0, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, access_count_o = 0.
  - Reset mid-transfer discards the transfer; no pulse follows.

## Timing
- Request sampled at edge N. ack/err is high during cycle N+1+WAIT_STATES.
- Bus inputs are not re-sampled between acceptance and termination; only cyc and stb are checked, for abort.
- If stb is still high after the termination cycle, it is taken as a new request in IDLE.
  - Minimum back-to-back spacing is therefore WAIT_STATES+2 cycles.
- ack and err are never high together, and never high for two consecutive cycles.
- Written data is visible to a read accepted in the cycle right after the write's ack.

## Configuration
- WB_RESPONDER_ERR_EN defined: an out-of-range access terminates with wb_err_o, not ack.
  - Memory is unchanged and wb_dat_o = 0.
- WB_RESPONDER_ERR_EN undefined: wb_err_o is tied 0.
  - Out-of-range accesses terminate with ack; writes are dropped and reads return 32'h0.

## Structure
- Package wb_responder_pkg:
  - state enum type (IDLE, WAIT, RESP);
  - constants WB_DATA_WIDTH = 32 and WB_SEL_WIDTH = 4;
  - function for word index and range check.
- Sub-module wb_responder_mem: DEPTH×32 byte-enable write array with synchronous clear, on wb_clk_i and wb_rst_i.
  - The top level holds the FSM, wait counter, output regs and statistics counter.

## Test plan
- WAIT_STATES=2: write 32'hDEADBEEF to adr 8'h04 with sel 4'hF, then read it back.
  - Expect ack 3 cycles after each request, read data 32'hDEADBEEF, access_count_o = 2.
- Byte lanes: write 32'h11223344 with sel 4'hF, then 32'hAABBCCDD with sel 4'b0101 to adr 8'h08.
  - Expect read 32'h11BB33DD.
- Abort: drop cyc in the cycle after acceptance, then read the target address.
  - Expect no ack for the aborted write, original data on read, count incremented by the read only.
- Out of range, adr 8'h40 with DEPTH=16:
  - with WB_RESPONDER_ERR_EN: one err pulse, no ack;
  - without it: ack, read returns 32'h0.
- Reset during WAIT after a write:
  - no ack afterwards, access_count_o = 0, every word reads 32'h0.
- WAIT_STATES=0 with stb held high for 4 transfers:
  - ack every 2nd cycle, never consecutive; count saturates correctly after 16'hFFFF forced transfers.
